// File: rtl/dbi_pkg.sv
// rtl/dbi_pkg.sv - DBI opcodes, sequencer state encoding and window-parameter helper
package dbi_pkg;

    localparam logic [7:0] SLPOUT = 8'h11;
    localparam logic [7:0] DISPON = 8'h29;
    localparam logic [7:0] CASET  = 8'h2A;
    localparam logic [7:0] RASET  = 8'h2B;
    localparam logic [7:0] RAMWR  = 8'h2C;
    localparam logic [7:0] MADCTL = 8'h36;
    localparam logic [7:0] COLMOD = 8'h3A;

    localparam logic [7:0] COLMOD_RGB565  = 8'h55;
    localparam logic [7:0] MADCTL_DEFAULT = 8'h00;

    typedef enum logic [2:0] {
        HRST_ST  = 3'd0,
        SLP_ST   = 3'd1,
        WAIT_ST  = 3'd2,
        INIT_ST  = 3'd3,
        CASET_ST = 3'd4,
        RASET_ST = 3'd5,
        RAMWR_ST = 3'd6
    } seq_state_e;

    // Window commands always start at 0: {0x00, 0x00, end[15:8], end[7:0]}
    function automatic logic [7:0] win_param(input logic [15:0] last_pos, input logic [1:0] pidx);
        case (pidx)
            2'd2:    win_param = last_pos[15:8];
            2'd3:    win_param = last_pos[7:0];
            default: win_param = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/dbi_tx_seq_if.sv
// rtl/dbi_tx_seq_if.sv - pixel byte stream in, command/data beats out to the DBI PHY
interface dbi_tx_seq_if #(
    parameter int DBI_IF_D_W = 8
);
    logic [7:0]            pxl_dat_i;
    logic                  pxl_vld_i;
    logic                  pxl_rdy_o;
    logic                  dtf_dbi_hrst_o;
    logic [7:0]            dtf_tx_cmd_typ_o;
    logic [DBI_IF_D_W-1:0] dtf_tx_cmd_dat_o;
    logic                  dtf_tx_no_dat_o;
    logic                  dtf_tx_last_o;
    logic                  dtf_tx_vld_o;
    logic                  dtf_tx_rdy_i;

    modport master (
        input  pxl_dat_i, pxl_vld_i, dtf_tx_rdy_i,
        output pxl_rdy_o, dtf_dbi_hrst_o, dtf_tx_cmd_typ_o, dtf_tx_cmd_dat_o,
               dtf_tx_no_dat_o, dtf_tx_last_o, dtf_tx_vld_o
    );

    modport slave (
        output pxl_dat_i, pxl_vld_i, dtf_tx_rdy_i,
        input  pxl_rdy_o, dtf_dbi_hrst_o, dtf_tx_cmd_typ_o, dtf_tx_cmd_dat_o,
               dtf_tx_no_dat_o, dtf_tx_last_o, dtf_tx_vld_o
    );
endinterface

// File: rtl/dbi_init_rom.sv
// rtl/dbi_init_rom.sv - power-up command table: SLPOUT, COLMOD, MADCTL, DISPON
module dbi_init_rom
    import dbi_pkg::*;
(
    input  logic [1:0] idx,
    input  logic [1:0] pidx,
    output logic [7:0] typ,
    output logic [1:0] pcnt,
    output logic [7:0] param
);

    always_comb begin
        typ   = SLPOUT;
        pcnt  = 2'd0;
        param = 8'h00;
        case (idx)
            2'd1: begin
                typ   = COLMOD;
                pcnt  = 2'd1;
                param = (pidx == 2'd0) ? COLMOD_RGB565 : 8'h00;
            end
            2'd2: begin
                typ   = MADCTL;
                pcnt  = 2'd1;
                param = MADCTL_DEFAULT;
            end
            2'd3:    typ = DISPON;
            default: typ = SLPOUT;
        endcase
    end

endmodule

// File: rtl/dbi_tx_seq.sv
// rtl/dbi_tx_seq.sv - panel bring-up and frame-loop command sequencer driving a DBI PHY
module dbi_tx_seq
    import dbi_pkg::*;
#(
    parameter int INTERNAL_CLK = 125000000,
    parameter int DBI_IF_D_W   = 8,
    parameter int IMG_W        = 240,
    parameter int IMG_H        = 320,
    parameter int T_SLP_CYC    = 15000000
) (
    input  logic         clk,
    input  logic         rst_n,
    dbi_tx_seq_if.master bus,
    output logic         init_done_o,
    output logic         frm_done_o
);

    localparam int PIX_BYTES = IMG_W * IMG_H * 2;
    localparam int CNT_W     = $clog2(PIX_BYTES);
    localparam int TMR_W     = $clog2(T_SLP_CYC + 1);

    localparam logic [15:0]      COL_LAST = 16'(IMG_W - 1);
    localparam logic [15:0]      ROW_LAST = 16'(IMG_H - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX_BYTES - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(T_SLP_CYC - 1);

    generate
        if (INTERNAL_CLK < 1 || T_SLP_CYC < 1 || PIX_BYTES < 2) begin : g_bad_param
            $error("dbi_tx_seq: invalid parameter set");
        end
    endgenerate

    seq_state_e state_q, state_d;

    logic                  run_q;
    logic [TMR_W-1:0]      tmr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [1:0]            idx_q;
    logic [1:0]            pidx_q;

    logic [7:0]            rom_typ;
    logic [1:0]            rom_pcnt;
    logic [7:0]            rom_param;

    logic                  tx_vld, tx_hrst, tx_no_dat, tx_last, pxl_rdy, beat;
    logic [7:0]            tx_typ;
    logic [DBI_IF_D_W-1:0] tx_dat;

    dbi_init_rom u_rom (
        .idx   (idx_q),
        .pidx  (pidx_q),
        .typ   (rom_typ),
        .pcnt  (rom_pcnt),
        .param (rom_param)
    );

    assign beat = tx_vld & bus.dtf_tx_rdy_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= HRST_ST;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HRST_ST:  if (beat) state_d = SLP_ST;
            SLP_ST:   if (beat) state_d = WAIT_ST;
            WAIT_ST:  if (tmr_q == '0) state_d = INIT_ST;
            INIT_ST:  if (beat && tx_last && idx_q == 2'd3) state_d = CASET_ST;
            CASET_ST: if (beat && tx_last) state_d = RASET_ST;
            RASET_ST: if (beat && tx_last) state_d = RAMWR_ST;
            RAMWR_ST: if (beat && tx_last) state_d = CASET_ST;
            default:  state_d = HRST_ST;
        endcase
    end

    always_comb begin
        tx_vld    = 1'b0;
        tx_hrst   = 1'b0;
        tx_typ    = 8'h00;
        tx_dat    = '0;
        tx_no_dat = 1'b0;
        tx_last   = 1'b0;
        pxl_rdy   = 1'b0;
        case (state_q)
            HRST_ST: begin
                tx_vld    = 1'b1;
                tx_hrst   = 1'b1;
                tx_no_dat = 1'b1;
                tx_last   = 1'b1;
            end
            SLP_ST, INIT_ST: begin
                tx_vld = 1'b1;
                tx_typ = rom_typ;
                if (rom_pcnt == 2'd0) begin
                    tx_no_dat = 1'b1;
                    tx_last   = 1'b1;
                end else begin
                    tx_dat  = DBI_IF_D_W'(rom_param);
                    tx_last = (pidx_q == rom_pcnt - 2'd1);
                end
            end
            CASET_ST: begin
                tx_vld  = 1'b1;
                tx_typ  = CASET;
                tx_dat  = DBI_IF_D_W'(win_param(COL_LAST, pidx_q));
                tx_last = (pidx_q == 2'd3);
            end
            RASET_ST: begin
                tx_vld  = 1'b1;
                tx_typ  = RASET;
                tx_dat  = DBI_IF_D_W'(win_param(ROW_LAST, pidx_q));
                tx_last = (pidx_q == 2'd3);
            end
            RAMWR_ST: begin
                tx_vld  = bus.pxl_vld_i;
                tx_typ  = RAMWR;
                tx_dat  = DBI_IF_D_W'(bus.pxl_dat_i);
                tx_last = (cnt_q == CNT_LAST);
                pxl_rdy = bus.dtf_tx_rdy_i;
            end
            default: tx_vld = 1'b0;
        endcase
        // Keep the bus quiet for the first cycle out of reset so every output reads 0 while held
        if (!run_q) begin
            tx_vld    = 1'b0;
            tx_hrst   = 1'b0;
            tx_no_dat = 1'b0;
            tx_last   = 1'b0;
            pxl_rdy   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= 1'b0;
            tmr_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            pidx_q      <= 2'd0;
            init_done_o <= 1'b0;
            frm_done_o  <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            frm_done_o <= (state_q == RAMWR_ST) && beat && tx_last;
            if (state_q == SLP_ST && beat)
                tmr_q <= TMR_LOAD;
            else if (state_q == WAIT_ST && tmr_q != '0)
                tmr_q <= tmr_q - TMR_W'(1);
            if (beat) begin
                case (state_q)
                    SLP_ST: idx_q <= 2'd1;
                    INIT_ST, CASET_ST, RASET_ST: begin
                        pidx_q <= tx_last ? 2'd0 : pidx_q + 2'd1;
                        if (state_q == INIT_ST && tx_last) begin
                            idx_q <= idx_q + 2'd1;
                            if (idx_q == 2'd3) init_done_o <= 1'b1;
                        end
                    end
                    RAMWR_ST: cnt_q <= tx_last ? '0 : cnt_q + CNT_W'(1);
                    default:  cnt_q <= cnt_q;
                endcase
            end
        end
    end

    assign bus.pxl_rdy_o        = pxl_rdy;
    assign bus.dtf_dbi_hrst_o   = tx_hrst;
    assign bus.dtf_tx_cmd_typ_o = tx_typ;
    assign bus.dtf_tx_cmd_dat_o = tx_dat;
    assign bus.dtf_tx_no_dat_o  = tx_no_dat;
    assign bus.dtf_tx_last_o    = tx_last;
    assign bus.dtf_tx_vld_o     = tx_vld;

endmodule

// File: tb/tb_dbi_tx_seq.sv
// tb/tb_dbi_tx_seq.sv - directed bench for dbi_tx_seq on a 2x2 panel with a 4-cycle sleep-out wait
module tb_dbi_tx_seq;

    logic clk = 1'b0;
    logic rst_n;
    logic init_done;
    logic frm_done;
    int   tests = 0;
    int   fails = 0;

    dbi_tx_seq_if #(.DBI_IF_D_W(8)) bus ();

    dbi_tx_seq #(
        .INTERNAL_CLK (125000000),
        .DBI_IF_D_W   (8),
        .IMG_W        (2),
        .IMG_H        (2),
        .T_SLP_CYC    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .init_done_o (init_done),
        .frm_done_o  (frm_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs just after the falling edge, then sample once combinational paths settle
    task automatic cyc(input logic vld, input logic [7:0] dat, input logic rdy);
        @(negedge clk);
        bus.pxl_vld_i    = vld;
        bus.pxl_dat_i    = dat;
        bus.dtf_tx_rdy_i = rdy;
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic hrst, input logic [7:0] typ,
                            input logic [7:0] dat, input logic nd, input logic last);
        chk({tag, " vld"},    bus.dtf_tx_vld_o,     1'b1);
        chk({tag, " hrst"},   bus.dtf_dbi_hrst_o,   hrst);
        chk({tag, " typ"},    bus.dtf_tx_cmd_typ_o, typ);
        chk({tag, " no_dat"}, bus.dtf_tx_no_dat_o,  nd);
        chk({tag, " last"},   bus.dtf_tx_last_o,    last);
        if (!nd) chk({tag, " dat"}, bus.dtf_tx_cmd_dat_o, dat);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " vld"},       bus.dtf_tx_vld_o,     1'b0);
        chk({tag, " hrst"},      bus.dtf_dbi_hrst_o,   1'b0);
        chk({tag, " typ"},       bus.dtf_tx_cmd_typ_o, 8'h00);
        chk({tag, " dat"},       bus.dtf_tx_cmd_dat_o, 8'h00);
        chk({tag, " no_dat"},    bus.dtf_tx_no_dat_o,  1'b0);
        chk({tag, " last"},      bus.dtf_tx_last_o,    1'b0);
        chk({tag, " pxl_rdy"},   bus.pxl_rdy_o,        1'b0);
        chk({tag, " init_done"}, init_done,            1'b0);
        chk({tag, " frm_done"},  frm_done,             1'b0);
    endtask

    task automatic win_cmd(input string tag, input logic [7:0] typ, input logic frm_first, input int stall);
        logic [7:0] exp_dat [4];
        exp_dat = '{8'h00, 8'h00, 8'h00, 8'h01};
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                for (int s = 0; s < stall; s++) begin
                    cyc(1'b1, 8'h5A, 1'b0);
                    chk_beat($sformatf("%s stall%0d", tag, s), 1'b0, typ, 8'h01, 1'b0, 1'b1);
                    chk($sformatf("%s stall%0d pxl_rdy", tag, s), bus.pxl_rdy_o, 1'b0);
                end
            end
            cyc(1'b1, 8'h5A, 1'b1);
            chk_beat($sformatf("%s p%0d", tag, i), 1'b0, typ, exp_dat[i], 1'b0, i == 3);
            chk($sformatf("%s p%0d pxl_rdy", tag, i), bus.pxl_rdy_o, 1'b0);
            chk($sformatf("%s p%0d frm_done", tag, i), frm_done, frm_first && i == 0);
            chk($sformatf("%s p%0d init_done", tag, i), init_done, 1'b1);
        end
    endtask

    task automatic ramwr(input string tag, input logic [7:0] base, input logic [7:0] gap_after, input int nbytes);
        for (int b = 0; b < nbytes; b++) begin
            cyc(1'b1, base + 8'(b), 1'b1);
            chk_beat($sformatf("%s b%0d", tag, b), 1'b0, 8'h2C, base + 8'(b), 1'b0, b == 7);
            chk($sformatf("%s b%0d pxl_rdy", tag, b), bus.pxl_rdy_o, 1'b1);
            chk($sformatf("%s b%0d frm_done", tag, b), frm_done, 1'b0);
            if (gap_after[3'(b)]) begin
                cyc(1'b0, 8'hEE, 1'b1);
                chk($sformatf("%s gap%0d vld", tag, b), bus.dtf_tx_vld_o, 1'b0);
                chk($sformatf("%s gap%0d pxl_rdy", tag, b), bus.pxl_rdy_o, 1'b1);
            end
        end
    endtask

    initial begin
        rst_n            = 1'b1;
        bus.pxl_vld_i    = 1'b1;
        bus.pxl_dat_i    = 8'h5A;
        bus.dtf_tx_rdy_i = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_quiet("reset");

        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 8'h5A, 1'b1);
        chk_beat("hrst", 1'b1, 8'h00, 8'h00, 1'b1, 1'b1);
        chk("hrst pxl_rdy", bus.pxl_rdy_o, 1'b0);
        cyc(1'b1, 8'h5A, 1'b1);
        chk_beat("slpout", 1'b0, 8'h11, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'h5A, 1'b1);
            chk($sformatf("wait%0d vld", i), bus.dtf_tx_vld_o, 1'b0);
            chk($sformatf("wait%0d pxl_rdy", i), bus.pxl_rdy_o, 1'b0);
        end
        cyc(1'b1, 8'h5A, 1'b1);
        chk_beat("colmod", 1'b0, 8'h3A, 8'h55, 1'b0, 1'b1);
        cyc(1'b1, 8'h5A, 1'b1);
        chk_beat("madctl", 1'b0, 8'h36, 8'h00, 1'b0, 1'b1);
        cyc(1'b1, 8'h5A, 1'b1);
        chk_beat("dispon", 1'b0, 8'h29, 8'h00, 1'b1, 1'b1);
        chk("dispon init_done", init_done, 1'b0);

        win_cmd("caset1", 8'h2A, 1'b0, 0);
        win_cmd("raset1", 8'h2B, 1'b0, 0);
        ramwr("ramwr1", 8'hA0, 8'h00, 8);

        win_cmd("caset2", 8'h2A, 1'b1, 5);
        win_cmd("raset2", 8'h2B, 1'b0, 0);
        ramwr("ramwr2", 8'hB0, 8'b0000_0101, 8);

        win_cmd("caset3", 8'h2A, 1'b1, 0);
        win_cmd("raset3", 8'h2B, 1'b0, 0);
        ramwr("ramwr3", 8'hC0, 8'h00, 3);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_quiet("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 8'h5A, 1'b1);
        chk_beat("hrst2", 1'b1, 8'h00, 8'h00, 1'b1, 1'b1);
        chk("hrst2 pxl_rdy", bus.pxl_rdy_o, 1'b0);
        cyc(1'b1, 8'h5A, 1'b1);
        chk_beat("slpout2", 1'b0, 8'h11, 8'h00, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dbi_tx_seq.md
DBI_TX_SEQ -- requirements
Module: dbi_tx_seq

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- INTERNAL_CLK, 125000000, clk frequency in Hz.
- DBI_IF_D_W, 8, DBI byte width.
- IMG_W, 240, panel columns.
- IMG_H, 320, panel rows.
- T_SLP_CYC, 15000000, post-SLPOUT wait in clk cycles (120 ms).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock, rising edge.
- rst_n, in, 1, reset, asynchronous, active-low.
- pxl_dat_i, in, 8, pixel byte stream, RGB565, high byte first.
- pxl_vld_i, in, 1, pixel byte valid.
- pxl_rdy_o, out, 1, pixel byte accepted.
- dtf_dbi_hrst_o, out, 1, request for a PHY hardware-reset transaction.
- dtf_tx_cmd_typ_o, out, 8, command opcode.
- dtf_tx_cmd_dat_o, out, 8, parameter or pixel byte.
- dtf_tx_no_dat_o, out, 1, command has no parameters.
- dtf_tx_last_o, out, 1, final byte of the transaction.
- dtf_tx_vld_o, out, 1, beat valid to the PHY.
- dtf_tx_rdy_i, in, 1, PHY ready.
- init_done_o, out, 1, level; init sequence complete.
- frm_done_o, out, 1, one-cycle pulse; frame fully sent.

Function
REQ-003 A beat is any cycle with dtf_tx_vld_o and dtf_tx_rdy_i both high.
REQ-004 The first beat of a transaction carries typ, the first parameter, no_dat and last; each later beat carries dat and last, with typ held.
REQ-005 While dtf_tx_vld_o is high and dtf_tx_rdy_i is low, all dtf_tx_* outputs are held stable, and vld is not withdrawn (except in RAMWR_ST).
REQ-006 After a non-final beat, the next beat is presented in the following cycle with vld held high.
REQ-007 no_dat=1 implies last=1, and the transaction is one beat long.
REQ-008 States: HRST_ST, SLP_ST, WAIT_ST, INIT_ST, CASET_ST, RASET_ST, RAMWR_ST.
REQ-009 HRST_ST presents one beat with hrst=1, typ=0x00, no_dat=1, last=1, then goes to SLP_ST.
REQ-010 SLP_ST sends 0x11 with no_dat=1; on its beat, the timer loads T_SLP_CYC-1 and the state goes to WAIT_ST.
REQ-011 WAIT_ST holds vld=0 and decrements the timer; at timer==0 it goes to INIT_ST, giving exactly T_SLP_CYC idle cycles.
REQ-012 INIT_ST sends three table entries in order: 0x3A with param 0x55, then 0x36 with param 0x00, then 0x29 with no_dat.
REQ-013 After the 0x29 beat, init_done_o is set (sticky until reset) and the state goes to CASET_ST.
REQ-014 CASET_ST sends 0x2A with params 0x00, 0x00, (IMG_W-1)[15:8], (IMG_W-1)[7:0]; last is set on the 4th beat.
REQ-015 RASET_ST sends 0x2B in the same pattern using IMG_H-1.
REQ-016 RAMWR_ST outputs, all combinational:
- typ=0x2C;
- dtf_tx_vld_o=pxl_vld_i;
- dtf_tx_cmd_dat_o=pxl_dat_i;
- pxl_rdy_o=dtf_tx_rdy_i.
REQ-017 Outside RAMWR_ST, pxl_rdy_o=0 and pxl_vld_i is ignored.
REQ-018 The byte counter has width clog2(IMG_W*IMG_H*2), increments only on beats, and last=1 when count==IMG_W*IMG_H*2-1.
REQ-019 On the last RAMWR beat:
- counter clears;
- frm_done_o pulses in the next cycle;
- state goes to CASET_ST, so frames loop indefinitely.
REQ-020 hrst_o=1 only in HRST_ST.
REQ-021 Latency from a beat to the next state's first beat is 1 cycle.

Reset
REQ-022 On rst_n low, outputs reset asynchronously: all dtf_tx_* outputs, hrst_o, pxl_rdy_o, init_done_o and frm_done_o go to 0.
REQ-023 On rst_n low, state goes to HRST_ST, the timer, byte counter and table index go to 0, and every register is cleared.
REQ-024 Reset asserted mid-operation aborts the current transaction; after release, the full sequence restarts from HRST_ST.

Structure
REQ-025 Shared package dbi_pkg holds:
- opcodes SLPOUT 0x11, DISPON 0x29, CASET 0x2A, RASET 0x2B, RAMWR 0x2C, MADCTL 0x36, COLMOD 0x3A;
- COLMOD_RGB565 0x55;
- state encodings.
REQ-026 Sub-module dbi_init_rom is combinational and maps a table index to {typ, param count, param byte by param index} for the SLP_ST and INIT_ST entries.

Verification (IMG_W=2, IMG_H=2, T_SLP_CYC=4)
REQ-027 Reset release with rdy_i=1 -> beats in order:
- hrst;
- 0x11 with no_dat;
- exactly 4 vld-low cycles;
- 0x3A/0x55 with last;
- 0x36/0x00 with last;
- 0x29 with no_dat;
- init_done_o rises the cycle after the 0x29 beat.
REQ-028 Post-init -> CASET beats: 0x2A with dat 00, 00, 00, 01, last on 01; then RASET 0x2B with the identical pattern.
REQ-029 Feed pixels 0xA0..0xA7 -> 8 RAMWR beats with typ 0x2C, last on 0xA7 only, frm_done_o for one cycle, then 0x2A appears next.
REQ-030 dtf_tx_rdy_i low for 5 cycles during CASET param 3 -> outputs bit-stable for all 5 cycles; no beat lost or duplicated.
REQ-031 pxl_vld_i toggling 1-0-1 during RAMWR -> vld_o mirrors it; the counter advances only on beats; last is still on the 8th byte.
REQ-032 rst_n pulsed after 3 RAMWR bytes -> all outputs 0 immediately; after release, the first beat is hrst.
